// File: rtl/dpram_rw_checker_if.sv
// Both ports of a true dual-port RAM: master drives enables/addresses/write data, slave returns read data.
// Pure wiring, no latency; the RAM is always ready so there is no backpressure.
interface dpram_rw_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              ram_en_a;
  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_wr_data_a;
  logic [DATA_W-1:0] ram_rd_data_a;
  logic              ram_en_b;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_wr_data_b;
  logic [DATA_W-1:0] ram_rd_data_b;

  modport master (
    output ram_en_a, ram_we_a, ram_addr_a, ram_wr_data_a,
    output ram_en_b, ram_we_b, ram_addr_b, ram_wr_data_b,
    input  ram_rd_data_a, ram_rd_data_b
  );

  modport slave (
    input  ram_en_a, ram_we_a, ram_addr_a, ram_wr_data_a,
    input  ram_en_b, ram_we_b, ram_addr_b, ram_wr_data_b,
    output ram_rd_data_a, ram_rd_data_b
  );
endinterface

// File: rtl/dpram_rw_checker.sv
// Writes P(a)=a^SEED via port A, reads back via B (optionally ~P via B, read via A) and counts mismatches.
// Test takes 2*DEPTH+RD_LAT (mode 0) or 4*DEPTH+2*RD_LAT (mode 1) cycles; start while busy is ignored.
module dpram_rw_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1,
  parameter logic [31:0] SEED   = 32'h0000_00A5
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_cnt,
  output logic [ADDR_W-1:0]  first_err_addr,
  dpram_rw_checker_if.master ram
);

  typedef enum logic [2:0] {
    IDLE, WR_A, RD_B, DRAIN_B, WR_B, RD_A, DRAIN_A, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT - 1);

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ DATA_W'(SEED);
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              mode_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              en_a_q;
  logic              we_a_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic [DATA_W-1:0] wd_a_q;
  logic              en_b_q;
  logic              we_b_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [DATA_W-1:0] wd_b_q;

  logic [15:0]       err_q;
  logic [15:0]       err_d;
  logic [ADDR_W-1:0] ferr_q;
  logic [ADDR_W-1:0] ferr_d;

  logic [ADDR_W-1:0] cnt_nx;
  logic              cnt_last;
  logic              drain_last;
  logic              accept;

  assign cnt_nx     = cnt_q + ADDR_W'(1);
  assign cnt_last   = (cnt_q == LAST);
  assign drain_last = (cnt_q == DRAIN_LAST);
  assign accept     = start && ((state_q == IDLE) || (state_q == DONE));

  // Port registers default to idle every cycle; each state issues the next access one edge ahead.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      en_a_q   <= 1'b0;
      we_a_q   <= 1'b0;
      addr_a_q <= '0;
      wd_a_q   <= '0;
      en_b_q   <= 1'b0;
      we_b_q   <= 1'b0;
      addr_b_q <= '0;
      wd_b_q   <= '0;
    end else begin
      en_a_q   <= 1'b0;
      we_a_q   <= 1'b0;
      addr_a_q <= '0;
      wd_a_q   <= '0;
      en_b_q   <= 1'b0;
      we_b_q   <= 1'b0;
      addr_b_q <= '0;
      wd_b_q   <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= WR_A;
            cnt_q   <= '0;
            mode_q  <= mode;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            en_a_q  <= 1'b1;
            we_a_q  <= 1'b1;
            wd_a_q  <= pat('0);
          end
        end
        WR_A: begin
          if (cnt_last) begin
            state_q <= RD_B;
            cnt_q   <= '0;
            en_b_q  <= 1'b1;
          end else begin
            cnt_q    <= cnt_nx;
            en_a_q   <= 1'b1;
            we_a_q   <= 1'b1;
            addr_a_q <= cnt_nx;
            wd_a_q   <= pat(cnt_nx);
          end
        end
        RD_B: begin
          if (cnt_last) begin
            state_q <= DRAIN_B;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_nx;
            en_b_q   <= 1'b1;
            addr_b_q <= cnt_nx;
          end
        end
        DRAIN_B: begin
          if (drain_last) begin
            cnt_q <= '0;
            if (mode_q) begin
              state_q <= WR_B;
              en_b_q  <= 1'b1;
              we_b_q  <= 1'b1;
              wd_b_q  <= ~pat('0);
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 16'd0);
            end
          end else begin
            cnt_q <= cnt_nx;
          end
        end
        WR_B: begin
          if (cnt_last) begin
            state_q <= RD_A;
            cnt_q   <= '0;
            en_a_q  <= 1'b1;
          end else begin
            cnt_q    <= cnt_nx;
            en_b_q   <= 1'b1;
            we_b_q   <= 1'b1;
            addr_b_q <= cnt_nx;
            wd_b_q   <= ~pat(cnt_nx);
          end
        end
        RD_A: begin
          if (cnt_last) begin
            state_q <= DRAIN_A;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_nx;
            en_a_q   <= 1'b1;
            addr_a_q <= cnt_nx;
          end
        end
        DRAIN_A: begin
          if (drain_last) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
          end else begin
            cnt_q <= cnt_nx;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The issued read (held in the port registers) enters an RD_LAT-deep pipeline; the last stage lines up with dout.
  logic                          iss_vld;
  logic                          iss_b;
  logic [DATA_W-1:0]             iss_exp;
  logic [ADDR_W-1:0]             iss_adr;
  logic [RD_LAT:1]               pv_q;
  logic [RD_LAT:1]               psel_q;
  logic [RD_LAT:1][DATA_W-1:0]   pexp_q;
  logic [RD_LAT:1][ADDR_W-1:0]   padr_q;
  logic [DATA_W-1:0]             rd_word;
  logic                          mism;

  always_comb begin
    iss_b   = en_b_q & ~we_b_q;
    iss_vld = iss_b | (en_a_q & ~we_a_q);
    iss_adr = iss_b ? addr_b_q : addr_a_q;
    iss_exp = iss_b ? pat(addr_b_q) : ~pat(addr_a_q);
  end

  always_comb begin
    rd_word = psel_q[RD_LAT] ? ram.ram_rd_data_b : ram.ram_rd_data_a;
    mism    = pv_q[RD_LAT] && (rd_word != pexp_q[RD_LAT]);
    err_d   = err_q;
    ferr_d  = ferr_q;
    if (mism) begin
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == 16'd0) begin
        ferr_d = padr_q[RD_LAT];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pv_q   <= '0;
      psel_q <= '0;
      pexp_q <= '0;
      padr_q <= '0;
      err_q  <= '0;
      ferr_q <= '0;
    end else begin
      pv_q[1]   <= iss_vld;
      psel_q[1] <= iss_b;
      pexp_q[1] <= iss_exp;
      padr_q[1] <= iss_adr;
      for (int i = 2; i <= RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        psel_q[i] <= psel_q[i-1];
        pexp_q[i] <= pexp_q[i-1];
        padr_q[i] <= padr_q[i-1];
      end
      if (accept) begin
        err_q  <= '0;
        ferr_q <= '0;
      end else begin
        err_q  <= err_d;
        ferr_q <= ferr_d;
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

  assign ram.ram_en_a      = en_a_q;
  assign ram.ram_we_a      = we_a_q;
  assign ram.ram_addr_a    = addr_a_q;
  assign ram.ram_wr_data_a = wd_a_q;
  assign ram.ram_en_b      = en_b_q;
  assign ram.ram_we_b      = we_b_q;
  assign ram.ram_addr_b    = addr_b_q;
  assign ram.ram_wr_data_b = wd_b_q;

endmodule

// File: tb/tb_dpram_rw_checker.sv
// Bench for dpram_rw_checker: default instance (8b/32 words/RD_LAT 1) with fault-injecting RAM model,
// plus a 16b/40-word/RD_LAT 2 instance; done-time results are checked by a scoreboard monitor.
module tb_dpram_rw_checker;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst0, start0, mode0, busy0, done0, pass0;
  logic [15:0] err0;
  logic [4:0]  ferr0;
  logic        rst1, start1, mode1, busy1, done1, pass1;
  logic [15:0] err1;
  logic [5:0]  ferr1;

  dpram_rw_checker_if #(.DATA_W(8),  .ADDR_W(5)) r0 ();
  dpram_rw_checker_if #(.DATA_W(16), .ADDR_W(6)) r1 ();

  dpram_rw_checker #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .SEED(32'hA5)) u0 (
    .sys_clk(sys_clk), .sys_rst(rst0), .start(start0), .mode(mode0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err_addr(ferr0),
    .ram(r0)
  );

  dpram_rw_checker #(.DATA_W(16), .ADDR_W(6), .DEPTH(40), .RD_LAT(2), .SEED(32'hA5)) u1 (
    .sys_clk(sys_clk), .sys_rst(rst1), .start(start1), .mode(mode1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(ferr1),
    .ram(r1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat8(input logic [4:0] a);
    return {3'b000, a} ^ 8'hA5;
  endfunction
  function automatic logic [7:0] npat8(input logic [4:0] a);
    return ~({3'b000, a} ^ 8'hA5);
  endfunction
  function automatic logic [15:0] pat16(input logic [5:0] a);
    return {10'd0, a} ^ 16'h00A5;
  endfunction

  // RAM models: instance 0 has 1-cycle read latency and fault hooks, instance 1 has 2-cycle latency.
  bit flip_b5 = 1'b0;
  bit stuck7  = 1'b0;
  logic [7:0]  mem0 [0:31];
  logic [15:0] mem1 [0:63];
  logic [15:0] s1a, s1b;

  function automatic logic [7:0] fault0(input logic [7:0] d, input logic [4:0] a, input bit port_b);
    logic [7:0] r;
    r = d;
    if (flip_b5 && port_b && a == 5'd5) r[0] = ~r[0];
    if (stuck7) r[7] = 1'b1;
    return r;
  endfunction

  always @(posedge sys_clk) begin
    if (r0.ram_en_a) begin
      if (r0.ram_we_a) mem0[r0.ram_addr_a] <= r0.ram_wr_data_a;
      else r0.ram_rd_data_a <= fault0(mem0[r0.ram_addr_a], r0.ram_addr_a, 1'b0);
    end
    if (r0.ram_en_b) begin
      if (r0.ram_we_b) mem0[r0.ram_addr_b] <= r0.ram_wr_data_b;
      else r0.ram_rd_data_b <= fault0(mem0[r0.ram_addr_b], r0.ram_addr_b, 1'b1);
    end
    if (r1.ram_en_a) begin
      if (r1.ram_we_a) mem1[r1.ram_addr_a] <= r1.ram_wr_data_a;
      else s1a <= mem1[r1.ram_addr_a];
    end
    if (r1.ram_en_b) begin
      if (r1.ram_we_b) mem1[r1.ram_addr_b] <= r1.ram_wr_data_b;
      else s1b <= mem1[r1.ram_addr_b];
    end
    r1.ram_rd_data_a <= s1a;
    r1.ram_rd_data_b <= s1b;
  end

  typedef struct {
    int cyc;
    int err;
    int ferr;
    bit pass;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   armed = 1'b0;
  int   bc0 = 0, bc1 = 0;
  bit   bprev0 = 1'b0, dprev0 = 1'b0, bprev1 = 1'b0, dprev1 = 1'b0;
  logic [5:0] max_a1 = '0, max_b1 = '0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (armed) begin
      if (r0.ram_en_a && r0.ram_we_a) chk("u0 wr_a data", r0.ram_wr_data_a, pat8(r0.ram_addr_a));
      if (r0.ram_en_a && r0.ram_we_a && r0.ram_addr_a == 5'd3) chk("u0 wr_a addr3", r0.ram_wr_data_a, 8'hA6);
      if (r0.ram_en_b && r0.ram_we_b) chk("u0 wr_b data", r0.ram_wr_data_b, npat8(r0.ram_addr_b));
      chk("u0 port overlap", r0.ram_en_a & r0.ram_en_b, 0);
      if (!r0.ram_en_a) chk("u0 idle a", {r0.ram_we_a, r0.ram_addr_a, r0.ram_wr_data_a}, 0);
      if (!r0.ram_en_b) chk("u0 idle b", {r0.ram_we_b, r0.ram_addr_b, r0.ram_wr_data_b}, 0);
      if (busy0) bc0 = bprev0 ? bc0 + 1 : 1;
      if (done0 && !dprev0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u0 done: no result expected, got err=%0d", err0);
        end else begin
          e = q0.pop_front();
          chk("u0 busy cycles", bc0, e.cyc);
          chk("u0 err_cnt", err0, e.err);
          chk("u0 first_err_addr", ferr0, e.ferr);
          chk("u0 pass", pass0, e.pass);
          chk("u0 busy at done", busy0, 0);
        end
      end
      if (r1.ram_en_a && r1.ram_we_a) chk("u1 wr_a data", r1.ram_wr_data_a, pat16(r1.ram_addr_a));
      if (r1.ram_en_a && r1.ram_addr_a > max_a1) max_a1 = r1.ram_addr_a;
      if (r1.ram_en_b && r1.ram_addr_b > max_b1) max_b1 = r1.ram_addr_b;
      if (busy1) bc1 = bprev1 ? bc1 + 1 : 1;
      if (done1 && !dprev1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u1 done: no result expected, got err=%0d", err1);
        end else begin
          e = q1.pop_front();
          chk("u1 busy cycles", bc1, e.cyc);
          chk("u1 err_cnt", err1, e.err);
          chk("u1 first_err_addr", ferr1, e.ferr);
          chk("u1 pass", pass1, e.pass);
        end
      end
    end
    bprev0 = busy0;
    dprev0 = done0;
    bprev1 = busy1;
    dprev1 = done1;
  end

  task automatic go(input int which, input bit m, input int cyc, input int err, input int ferr, input bit p);
    exp_t e;
    e.cyc  = cyc;
    e.err  = err;
    e.ferr = ferr;
    e.pass = p;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
    @(negedge sys_clk);
    if (which == 0) begin mode0 = m; start0 = 1'b1; end
    else begin mode1 = m; start1 = 1'b1; end
    @(negedge sys_clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? done0 : done1) == 1'b0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (which == 0) chk("u0 done within budget", done0, 1);
    else chk("u1 done within budget", done1, 1);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    int n;
    rst0 = 1'b1; rst1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    mode0 = 1'b0; mode1 = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst u0 busy/done/pass", {busy0, done0, pass0}, 0);
    chk("rst u0 err/ferr", {err0, ferr0}, 0);
    chk("rst u0 port a", {r0.ram_en_a, r0.ram_we_a, r0.ram_addr_a, r0.ram_wr_data_a}, 0);
    chk("rst u0 port b", {r0.ram_en_b, r0.ram_we_b, r0.ram_addr_b, r0.ram_wr_data_b}, 0);
    chk("rst u1 status", {busy1, done1, pass1, err1, ferr1}, 0);
    chk("rst u1 enables", {r1.ram_en_a, r1.ram_we_a, r1.ram_en_b, r1.ram_we_b}, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    armed = 1'b1;

    // mode 0, ideal RAM: 2*32+1 busy cycles
    go(0, 1'b0, 65, 0, 0, 1'b1);
    wait_done(0, 200);

    // bit 0 flipped on port B read of addr 5
    flip_b5 = 1'b1;
    go(0, 1'b0, 65, 1, 5, 1'b0);
    wait_done(0, 200);
    flip_b5 = 1'b0;

    // mode 1, ideal RAM: 4*32+2 busy cycles
    go(0, 1'b1, 130, 0, 0, 1'b1);
    wait_done(0, 300);

    // bit 7 stuck at 1: P(a)=a^A5 has bit7=1 for every a<32, so pass 1 is clean;
    // ~P(a) has bit7=0 everywhere, so all 32 pass-2 reads fail, first at addr 0.
    stuck7 = 1'b1;
    go(0, 1'b1, 130, 32, 0, 1'b0);
    wait_done(0, 300);
    stuck7 = 1'b0;

    // reset while writing addr 10 aborts the test with no further RAM access
    @(negedge sys_clk);
    mode0 = 1'b0;
    start0 = 1'b1;
    @(negedge sys_clk);
    start0 = 1'b0;
    n = 0;
    while (!(r0.ram_en_a && r0.ram_we_a && r0.ram_addr_a == 5'd10) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("u0 reached wr addr 10", {r0.ram_en_a, r0.ram_we_a, r0.ram_addr_a}, {2'b11, 5'd10});
    rst0 = 1'b1;
    @(negedge sys_clk);
    chk("abort enables", {r0.ram_en_a, r0.ram_we_a, r0.ram_en_b, r0.ram_we_b}, 0);
    chk("abort busy", busy0, 0);
    chk("abort done", done0, 0);
    rst0 = 1'b0;
    go(0, 1'b0, 65, 0, 0, 1'b1);
    wait_done(0, 200);

    // start (with mode=1) during RD_B is ignored
    go(0, 1'b0, 65, 0, 0, 1'b1);
    n = 0;
    while (!(r0.ram_en_b && !r0.ram_we_b && r0.ram_addr_b == 5'd8) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("u0 reached rd_b addr 8", {r0.ram_en_b, r0.ram_we_b, r0.ram_addr_b}, {2'b10, 5'd8});
    mode0 = 1'b1;
    start0 = 1'b1;
    @(negedge sys_clk);
    start0 = 1'b0;
    mode0 = 1'b0;
    wait_done(0, 200);

    // wide instance: DEPTH=40, RD_LAT=2 -> 2*40+2 busy cycles
    max_a1 = '0;
    max_b1 = '0;
    go(1, 1'b0, 82, 0, 0, 1'b1);
    wait_done(1, 300);
    chk("u1 max addr a", max_a1, 39);
    chk("u1 max addr b", max_b1, 39);

    chk("u0 scoreboard drained", q0.size(), 0);
    chk("u1 scoreboard drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
